// File: rtl/imm_encoder.sv
// RV32I immediate encoder: splices a 32-bit immediate into the field slots of an
// instruction template, with range checking, a write-address counter and an error counter.
module imm_encoder #(
   parameter int ADDR_W     = 8,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_fmt,
   input  logic [31:0]       in_imm,
   input  logic [31:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [7:0]        err_cnt,
   output logic              busy
);

   localparam logic [5:0] F_SHAMT = 6'b100000;
   localparam logic [5:0] F_I     = 6'b010000;
   localparam logic [5:0] F_S     = 6'b001000;
   localparam logic [5:0] F_B     = 6'b000100;
   localparam logic [5:0] F_U     = 6'b000010;
   localparam logic [5:0] F_J     = 6'b000001;

   localparam logic [ADDR_W-1:0] L_START = START_ADDR[ADDR_W-1:0];

   logic              r_a_valid;
   logic [5:0]        r_a_fmt;
   logic [31:0]       r_a_imm;
   logic [31:0]       r_a_instr;
   logic              r_a_err;

   logic              r_out_valid;
   logic [31:0]       r_out_instr;
   logic              r_out_err;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_err_cnt;

   logic              w_b_free;
   logic              w_in_hs;
   logic              w_a_to_b;
   logic              w_out_hs;
   logic              w_eq11;
   logic              w_eq12;
   logic              w_eq20;
   logic              w_in_err;
   logic [31:0]       w_pack;

   assign w_b_free = !r_out_valid || out_ready;
   assign in_ready = !r_a_valid || w_b_free;
   assign w_in_hs  = in_valid && in_ready;
   assign w_a_to_b = r_a_valid && w_b_free;
   assign w_out_hs = r_out_valid && out_ready;

   // Sign-extension checks: the named upper bits must be all ones or all zeros.
   assign w_eq11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign w_eq12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
   assign w_eq20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

   always_comb begin
      w_in_err = 1'b1;
      case (in_fmt)
         F_SHAMT:  w_in_err = |in_imm[31:5];
         F_I, F_S: w_in_err = !w_eq11;
         F_B:      w_in_err = in_imm[0] | !w_eq12;
         F_U:      w_in_err = |in_imm[11:0];
         F_J:      w_in_err = in_imm[0] | !w_eq20;
         default:  w_in_err = 1'b1;
      endcase
   end

   // Packing happens between the stages so stage A only carries raw request fields.
   always_comb begin
      w_pack = r_a_instr;
      case (r_a_fmt)
         F_SHAMT: w_pack[24:20] = r_a_imm[4:0];
         F_I:     w_pack[31:20] = r_a_imm[11:0];
         F_S: begin
            w_pack[31:25] = r_a_imm[11:5];
            w_pack[11:7]  = r_a_imm[4:0];
         end
         F_B: begin
            w_pack[31]    = r_a_imm[12];
            w_pack[30:25] = r_a_imm[10:5];
            w_pack[11:8]  = r_a_imm[4:1];
            w_pack[7]     = r_a_imm[11];
         end
         F_U:     w_pack[31:12] = r_a_imm[31:12];
         F_J: begin
            w_pack[31]    = r_a_imm[20];
            w_pack[30:21] = r_a_imm[10:1];
            w_pack[20]    = r_a_imm[11];
            w_pack[19:12] = r_a_imm[19:12];
         end
         default: w_pack = r_a_instr;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_a_valid   <= 1'b0;
         r_a_fmt     <= '0;
         r_a_imm     <= '0;
         r_a_instr   <= '0;
         r_a_err     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_err   <= 1'b0;
         r_addr      <= L_START;
         r_err_cnt   <= '0;
      end else if (clear) begin
         r_a_valid   <= 1'b0;
         r_out_valid <= 1'b0;
         r_addr      <= L_START;
         r_err_cnt   <= '0;
      end else begin
         if (w_in_hs) begin
            r_a_valid <= 1'b1;
            r_a_fmt   <= in_fmt;
            r_a_imm   <= in_imm;
            r_a_instr <= in_instr;
            r_a_err   <= w_in_err;
         end else if (w_a_to_b) begin
            r_a_valid <= 1'b0;
         end

         if (w_a_to_b) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_pack;
            r_out_err   <= r_a_err;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_out_hs) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_out_err && (r_err_cnt != 8'hFF))
               r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_err   = r_out_err;
   assign out_addr  = r_addr;
   assign err_cnt   = r_err_cnt;
   assign busy      = r_a_valid | r_out_valid;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors, backpressure, counters, flush/reset and a random
// soak scored against an arithmetic encoder model plus a field-decoding round-trip check.
module tb_imm_encoder;

   localparam int AW = 2;

   localparam logic [5:0] F_SH = 6'b100000;
   localparam logic [5:0] F_I  = 6'b010000;
   localparam logic [5:0] F_S  = 6'b001000;
   localparam logic [5:0] F_B  = 6'b000100;
   localparam logic [5:0] F_U  = 6'b000010;
   localparam logic [5:0] F_J  = 6'b000001;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [5:0]  fmt;
      logic [31:0] imm;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [5:0]    in_fmt = '0;
   logic [31:0]   in_imm = '0;
   logic [31:0]   in_instr = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic          out_err;
   logic [7:0]    err_cnt;
   logic          busy;

   imm_encoder #(.ADDR_W(AW), .START_ADDR(0)) dut (
      .clk(clk), .rstn(rstn), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
      .in_imm(in_imm), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   logic [AW-1:0] exp_addr = '0;
   int exp_cnt = 0;
   int n_out = 0;

   logic        s_out_valid, s_in_ready, s_out_err, s_acc;
   logic [31:0] s_out_instr;
   logic [7:0]  s_err_cnt;
   logic [AW-1:0] s_out_addr;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_instr;
   logic        prev_err;
   logic [AW-1:0] prev_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Encoder model from the field tables: a bit mask of overwritten positions and the
   // immediate bits shifted into place; range decided with signed integer bounds.
   function automatic exp_t model(input logic [5:0] f, input logic [31:0] imm, input logic [31:0] tp);
      exp_t r;
      int s;
      logic [31:0] m, fld;
      s = $signed(imm);
      m = 32'h0; fld = 32'h0; r.err = 1'b1;
      case (f)
         F_SH: begin
            m = 32'h01F0_0000; fld = (imm & 32'd31) << 20; r.err = (imm > 32'd31);
         end
         F_I: begin
            m = 32'hFFF0_0000; fld = (imm & 32'hFFF) << 20; r.err = (s < -2048) || (s > 2047);
         end
         F_S: begin
            m = 32'hFE00_0F80;
            fld = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            r.err = (s < -2048) || (s > 2047);
         end
         F_B: begin
            m = 32'hFE00_0F80;
            fld = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            r.err = imm[0] || (s < -4096) || (s > 4095);
         end
         F_U: begin
            m = 32'hFFFF_F000; fld = imm & 32'hFFFF_F000; r.err = ((imm & 32'hFFF) != 0);
         end
         F_J: begin
            m = 32'hFFFF_F000;
            fld = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
            r.err = imm[0] || (s < -1048576) || (s > 1048575);
         end
         default: r.err = 1'b1;
      endcase
      r.instr = (tp & ~m) | fld;
      r.fmt = f;
      r.imm = imm;
      return r;
   endfunction

   // Forward immediate extender, used for the round-trip property.
   function automatic logic [31:0] decode(input logic [5:0] f, input logic [31:0] w);
      case (f)
         F_SH:    return {27'b0, w[24:20]};
         F_I:     return {{20{w[31]}}, w[31:20]};
         F_S:     return {{20{w[31]}}, w[31:25], w[11:7]};
         F_B:     return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         F_U:     return {w[31:12], 12'b0};
         F_J:     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   task automatic cycle(input logic v, input logic [5:0] f, input logic [31:0] im,
                        input logic [31:0] tp, input logic ordy, input logic clr);
      exp_t e;
      @(negedge clk);
      in_valid = v; in_fmt = f; in_imm = im; in_instr = tp; out_ready = ordy; clear = clr;
      #1;
      s_out_valid = out_valid; s_in_ready = in_ready; s_out_err = out_err;
      s_out_instr = out_instr; s_out_addr = out_addr; s_err_cnt = err_cnt;
      s_acc = v && in_ready && !clr;
      check("busy", busy, (q.size() != 0));
      check("err_cnt", err_cnt, exp_cnt);
      if (prev_stall) begin
         check("hold_valid", out_valid, 1'b1);
         check("hold_instr", out_instr, prev_instr);
         check("hold_err", out_err, prev_err);
         check("hold_addr", out_addr, prev_addr);
      end
      prev_stall = out_valid && !ordy && !clr;
      prev_instr = out_instr; prev_err = out_err; prev_addr = out_addr;
      if (out_valid && ordy && !clr) begin
         if (q.size() == 0) begin
            check("unexpected_out", out_valid, 1'b0);
         end else begin
            e = q.pop_front();
            $display("OUT addr=%0d instr=%h err=%0d", out_addr, out_instr, out_err);
            check("instr", out_instr, e.instr);
            check("err", out_err, e.err);
            check("addr", out_addr, exp_addr);
            if (!e.err) check("roundtrip", decode(e.fmt, out_instr), e.imm);
            exp_addr = exp_addr + 1'b1;
            if (e.err && exp_cnt != 255) exp_cnt++;
            n_out++;
         end
      end
      if (clr) begin
         q.delete(); exp_addr = '0; exp_cnt = 0;
      end else if (s_acc) begin
         q.push_back(model(f, im, tp));
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 6'b0, 32'h0, 32'h0, ordy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
      rstn = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      q.delete(); exp_addr = '0; exp_cnt = 0; prev_stall = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         idle(1'b1);
         n++;
      end
      check("drain_timeout", q.size(), 0);
   endtask

   logic [5:0]  d_fmt [10] = '{F_I, F_I, F_B, F_B, F_J, F_U, F_U, 6'b000011, F_SH, F_S};
   logic [31:0] d_imm [10] = '{32'hFFFFFFFF, 32'h800, 32'hFFFFFFFE, 32'h3, 32'h800,
                               32'h12345000, 32'h12345001, 32'h5, 32'h1F, 32'hFFFFF800};
   logic [31:0] d_tp  [10] = '{32'h13, 32'h13, 32'h63, 32'h63, 32'h6F, 32'h37, 32'h37,
                               32'hABCDE013, 32'h40005013, 32'h00002023};
   logic [31:0] d_exp [10] = '{32'hFFF00013, 32'h80000013, 32'hFE000FE3, 32'h00000163,
                               32'h0010006F, 32'h12345037, 32'h12345037, 32'hABCDE013,
                               32'h41F05013, 32'h80002023};
   logic        d_err [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, outs0, t;
      logic [31:0] stall_instr;
      logic [5:0] fmts [7];
      fmts = '{F_SH, F_I, F_S, F_B, F_U, F_J, 6'b0};

      #2;
      check("rst_valid", out_valid, 1'b0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_err", out_err, 1'b0);
      check("rst_addr", out_addr, 0);
      check("rst_cnt", err_cnt, 0);
      do_reset();

      // Directed vectors, each with latency observed.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, d_fmt[i], d_imm[i], d_tp[i], 1'b1, 1'b0);
         check("dir_accept", s_in_ready, 1'b1);
         idle(1'b1);
         check("dir_lat1", s_out_valid, 1'b0);
         idle(1'b1);
         check("dir_lat2", s_out_valid, 1'b1);
         check("dir_instr", s_out_instr, d_exp[i]);
         check("dir_err", s_out_err, d_err[i]);
      end
      idle(1'b1);
      check("dir_errcnt", s_err_cnt, 8'd4);

      // Backpressure: output stalled while four requests are offered.
      do_reset();
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         cycle(1'b1, F_I, idx + 1, 32'h13, 1'b0, 1'b0);
         if (s_acc) idx++;
         if (c == 2) stall_instr = s_out_instr;
      end
      check("bp_accepted", idx, 2);
      check("bp_in_ready", s_in_ready, 1'b0);
      check("bp_stable", s_out_instr, stall_instr);
      t = 0;
      while (idx < 4 && t < 50) begin
         cycle(1'b1, F_I, idx + 1, 32'h13, 1'b1, 1'b0);
         if (s_acc) idx++;
         t++;
      end
      drain(20);
      check("bp_outs", n_out, 14);
      cycle(1'b1, F_I, 32'h7, 32'h13, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      check("wrap_addr", s_out_addr, 0);
      drain(10);

      // Saturating error counter with back-to-back throughput.
      do_reset();
      outs0 = n_out;
      for (int i = 0; i < 300; i++) cycle(1'b1, 6'b0, i, 32'h13, 1'b1, 1'b0);
      repeat (3) idle(1'b1);
      check("sat_outs", n_out - outs0, 300);
      check("sat_cnt", s_err_cnt, 8'd255);

      // Clear together with an input handshake.
      for (int i = 0; i < 3; i++) cycle(1'b1, F_U, 32'h1000 * i, 32'h37, 1'b1, 1'b0);
      drain(10);
      cycle(1'b1, F_I, 32'h1, 32'h13, 1'b0, 1'b0);
      idle(1'b0);
      cycle(1'b1, F_I, 32'h2, 32'h13, 1'b1, 1'b1);
      check("clr_hs_ready", s_in_ready, 1'b1);
      idle(1'b1);
      check("clr_valid", s_out_valid, 1'b0);
      check("clr_addr", s_out_addr, 0);
      check("clr_cnt", s_err_cnt, 8'd0);

      // Asynchronous reset while a word is waiting.
      cycle(1'b1, F_I, 32'h5, 32'h13, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("arst_pre", s_out_valid, 1'b1);
      #1 rstn = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_addr", out_addr, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      q.delete(); exp_addr = '0; exp_cnt = 0; prev_stall = 1'b0;

      // Random soak.
      for (int c = 0; c < 800; c++) begin
         logic [5:0] f;
         logic [31:0] im;
         int k;
         k = $urandom_range(0, 6);
         f = (k == 6) ? 6'($urandom) : fmts[k];
         if ($urandom_range(0, 1) == 0) begin
            case (f)
               F_SH:     im = $urandom_range(0, 31);
               F_I, F_S: im = 32'($urandom_range(0, 4095)) - 32'd2048;
               F_B:      im = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'h1;
               F_J:      im = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'h1;
               F_U:      im = $urandom & 32'hFFFF_F000;
               default:  im = $urandom;
            endcase
         end else begin
            im = $urandom;
         end
         cycle(1'($urandom_range(0, 1)), f, im, $urandom, 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 63) == 0));
      end
      drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
